// File: rtl/udp_rx_reader_pkg.sv
// Shared constants, FSM state type and skid entry layout for the UDP receive reader.
package udp_rx_reader_pkg;

  localparam int UDP_HDR_LEN     = 8;
  localparam int UDP_RAM_AW      = 11;
  localparam int UDP_MAX_PAYLOAD = 2048;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } skid_entry_t;

  // Payload length after stripping the header; 0 means the indication is unusable.
  function automatic logic [15:0] payload_len(input logic [15:0] udp_len,
                                              input int          hdr_len,
                                              input int          max_payload);
    logic [15:0] plen;
    if (udp_len <= 16'(hdr_len)) begin
      plen = 16'd0;
    end else begin
      plen = udp_len - 16'(hdr_len);
      if (plen > 16'(max_payload)) plen = 16'(max_payload);
    end
    return plen;
  endfunction

endpackage

// File: rtl/udp_rx_reader_if.sv
// Payload byte stream with valid/ready handshake, packet delimiters and packet length.
interface udp_rx_reader_if;

  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sof;
  logic        m_eof;
  logic [15:0] m_len;

  modport master (output m_data, m_valid, m_sof, m_eof, m_len, input m_ready);
  modport slave  (input m_data, m_valid, m_sof, m_eof, m_len, output m_ready);

endinterface

// File: rtl/udp_rx_reader_skid.sv
// Two-entry FIFO behind the RAM read port; a read landing on an empty FIFO is presented directly.
module udp_rx_skid
  import udp_rx_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic        issue_sof,
  input  logic        issue_eof,
  input  logic [7:0]  rdata,
  input  logic        pop,
  output logic        head_valid,
  output skid_entry_t head,
  output logic [1:0]  occupancy
);

  skid_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        pend;
  logic        pend_sof;
  logic        pend_eof;
  skid_entry_t ret;
  logic        push;
  logic        pop_mem;

  assign ret        = {pend_sof, pend_eof, rdata};
  assign head_valid = (count != 2'd0) || pend;
  assign pop_mem    = pop && (count != 2'd0);
  // The returning byte is stored unless it bypasses straight to the sink this cycle.
  assign push       = pend && !((count == 2'd0) && pop);
  assign occupancy  = count + {1'b0, pend};

  always_comb begin
    head = '0;
    if (count != 2'd0) head = mem[rd_ptr];
    else if (pend)     head = ret;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      pend     <= 1'b0;
      pend_sof <= 1'b0;
      pend_eof <= 1'b0;
    end else begin
      pend     <= issue;
      pend_sof <= issue_sof;
      pend_eof <= issue_eof;
      if (push) begin
        mem[wr_ptr] <= ret;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_mem) rd_ptr <= ~rd_ptr;
      case ({push, pop_mem})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udp_rx_reader.sv
// Reads each completed UDP payload out of the receive RAM and streams it with sof/eof framing.
module udp_rx_reader
  import udp_rx_reader_pkg::*;
#(
  parameter int RAM_AW      = UDP_RAM_AW,
  parameter int HDR_LEN     = UDP_HDR_LEN,
  parameter int MAX_PAYLOAD = UDP_MAX_PAYLOAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              udp_rec_data_valid,
  input  logic [15:0]       udp_rec_data_length,
  output logic [RAM_AW-1:0] udp_rec_ram_read_addr,
  input  logic [7:0]        udp_rec_ram_rdata,
  udp_rx_reader_if.master   m,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int LW = $clog2(MAX_PAYLOAD + 1);

  rd_state_t         state;
  rd_state_t         next_state;
  logic [RAM_AW-1:0] rd_addr;
  logic [LW-1:0]     rd_left;
  logic [15:0]       len_q;
  logic [15:0]       plen;
  logic              accept;
  logic              drop;
  logic              issue;
  logic              pop;
  logic              head_valid;
  skid_entry_t       head;
  logic [1:0]        occupancy;

  assign plen = payload_len(udp_rec_data_length, HDR_LEN, MAX_PAYLOAD);
  assign pop  = head_valid && m.m_ready;

  // Only one RAM read may be outstanding per free skid slot, so the sink can stall at any time.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drop       = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (udp_rec_data_valid) begin
          if (plen != 16'd0) begin
            accept     = 1'b1;
            next_state = READ;
          end else begin
            drop = 1'b1;
          end
        end
      end
      READ: begin
        drop  = udp_rec_data_valid;
        issue = (occupancy < 2'd2);
        if (issue && (rd_left == LW'(1))) next_state = DRAIN;
      end
      DRAIN: begin
        drop = udp_rec_data_valid;
        if (pop && head.eof) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      rd_left  <= '0;
      len_q    <= 16'd0;
      drop_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        rd_addr <= '0;
        rd_left <= plen[LW-1:0];
        len_q   <= plen;
      end else if (issue) begin
        rd_addr <= rd_addr + RAM_AW'(1);
        rd_left <= rd_left - LW'(1);
      end
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  udp_rx_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_sof  (rd_left == LW'(len_q)),
    .issue_eof  (rd_left == LW'(1)),
    .rdata      (udp_rec_ram_rdata),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head),
    .occupancy  (occupancy)
  );

  assign udp_rec_ram_read_addr = rd_addr;
  assign busy                  = (state != IDLE);
  assign m.m_valid             = head_valid;
  assign m.m_data              = head.data;
  assign m.m_sof               = head.sof;
  assign m.m_eof               = head.eof;
  assign m.m_len               = len_q;

endmodule
